// File: rtl/ahb_subordinate_mem_responder_if.sv
// AHB-Lite bus bundle between a master agent and the memory responder.
interface ahb_subordinate_mem_responder_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                    hselx;
   logic [ADDR_WIDTH-1:0]   haddr;
   logic [1:0]              htrans;
   logic                    hwrite;
   logic [2:0]              hsize;
   logic [2:0]              hburst;
   logic [DATA_WIDTH-1:0]   hwdata;
   logic [DATA_WIDTH/8-1:0] hwstrb;
   logic                    hready;
   logic                    hreadyout;
   logic                    hresp;
   logic [DATA_WIDTH-1:0]   hrdata;

   modport master (
      output hselx, haddr, htrans, hwrite, hsize, hburst, hwdata, hwstrb, hready,
      input  hreadyout, hresp, hrdata
   );

   modport slave (
      input  hselx, haddr, htrans, hwrite, hsize, hburst, hwdata, hwstrb, hready,
      output hreadyout, hresp, hrdata
   );
endinterface

// File: rtl/ahb_subordinate_mem_responder.sv
// AHB subordinate memory model: programmable wait states, two-cycle ERROR response,
// byte-strobed write storage and lane-masked read data.
module ahb_subordinate_mem_responder #(
   parameter int unsigned            ADDR_WIDTH    = 32,
   parameter int unsigned            DATA_WIDTH    = 32,
   parameter int unsigned            MEM_ADDR_BITS = 12,
   parameter logic [ADDR_WIDTH-1:0]  MIN_ADDR      = ADDR_WIDTH'(32'h0000_0000),
   parameter logic [ADDR_WIDTH-1:0]  MAX_ADDR      = ADDR_WIDTH'(32'h0000_0FFF),
   parameter int unsigned            WAIT_WIDTH    = 5
) (
   input  logic                   hclk,
   input  logic                   hresetn,
   ahb_subordinate_mem_responder_if.slave bus,
   input  logic [WAIT_WIDTH-1:0]  cfg_wait_states
);

   localparam int unsigned NB        = DATA_WIDTH / 8;
   localparam int unsigned NB_LOG2   = $clog2(NB);
   localparam int unsigned WORD_BITS = MEM_ADDR_BITS - NB_LOG2;
   localparam int unsigned MEM_BYTES = 1 << MEM_ADDR_BITS;

   typedef enum logic [2:0] {StIdle, StWait, StErr1, StErr2, StOkay} state_e;

   state_e                 state_q, state_d;
   logic [WAIT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                   write_q;
   logic [NB-1:0]          mask_q, mask_d;
   logic [WORD_BITS-1:0]   word_q;
   logic                   latch;

   logic                   ready_out;
   logic                   resp_out;
   logic [DATA_WIDTH-1:0]  rdata_out;
   logic                   commit;

   logic [7:0]             mem [MEM_BYTES];

   // Address-phase decode, evaluated with one spare bit so overflow and borrow are visible.
   logic [ADDR_WIDTH:0]    addr_ext, offset_ext, size_bytes, end_addr;
   logic                   size_err, align_err, low_err, high_err, xfer_err;
   int unsigned            lane_off, lane_cnt;

   assign addr_ext   = {1'b0, bus.haddr};
   assign offset_ext = addr_ext - {1'b0, MIN_ADDR};
   assign size_bytes = (ADDR_WIDTH+1)'(1) << bus.hsize;
   assign end_addr   = addr_ext + size_bytes - (ADDR_WIDTH+1)'(1);
   assign size_err   = bus.hsize > 3'(NB_LOG2);
   assign align_err  = (addr_ext & (size_bytes - (ADDR_WIDTH+1)'(1))) != '0;
   assign low_err    = offset_ext[ADDR_WIDTH];
   assign high_err   = end_addr > {1'b0, MAX_ADDR};
   assign xfer_err   = size_err | align_err | low_err | high_err;

   // Byte lanes covered by the addressed size, relative to the bus word.
   always_comb begin
      lane_off = 32'(bus.haddr[NB_LOG2-1:0]);
      lane_cnt = 32'd1 << bus.hsize;
      mask_d   = '0;
      for (int unsigned i = 0; i < NB; i++) begin
         mask_d[i] = (i >= lane_off) && (i < lane_off + lane_cnt);
      end
   end

   // Next-state and handshake outputs; IDLE, OKAY and ERR2 are all address-accept points.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      latch     = 1'b0;
      ready_out = 1'b1;
      resp_out  = 1'b0;
      case (state_q)
         StIdle, StOkay, StErr2: begin
            resp_out = (state_q == StErr2);
            if (bus.hready) begin
               state_d = StIdle;
               if (bus.hselx && bus.htrans[1]) begin
                  latch = 1'b1;
                  if (xfer_err) begin
                     state_d = StErr1;
                  end else if (cfg_wait_states != '0) begin
                     state_d = StWait;
                     cnt_d   = cfg_wait_states - WAIT_WIDTH'(1);
                  end else begin
                     state_d = StOkay;
                  end
               end
            end
         end
         StWait: begin
            ready_out = 1'b0;
            if (cnt_q == '0) begin
               state_d = StOkay;
            end else begin
               cnt_d = cnt_q - WAIT_WIDTH'(1);
            end
         end
         StErr1: begin
            ready_out = 1'b0;
            resp_out  = 1'b1;
            state_d   = StErr2;
         end
         default: state_d = StIdle;
      endcase
   end

   // State register and latched address phase.
   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         write_q <= 1'b0;
         mask_q  <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (latch) begin
            write_q <= bus.hwrite;
            mask_q  <= mask_d;
            // MIN_ADDR is assumed bus-word aligned, so the offset's low bits are the lane.
            word_q  <= offset_ext[MEM_ADDR_BITS-1:NB_LOG2];
         end
      end
   end

   assign commit = (state_q == StOkay) && write_q && bus.hready;

   // Byte-strobed write on the completing edge of an OKAY write; reset drops it.
   always_ff @(posedge hclk) begin
      if (hresetn && commit) begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (bus.hwstrb[i] && mask_q[i]) begin
               mem[{word_q, NB_LOG2'(i)}] <= bus.hwdata[8*i +: 8];
            end
         end
      end
   end

   // Read data only in the completing cycle of an OKAY read; unaddressed lanes are zero.
   always_comb begin
      rdata_out = '0;
      if ((state_q == StOkay) && !write_q) begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (mask_q[i]) begin
               rdata_out[8*i +: 8] = mem[{word_q, NB_LOG2'(i)}];
            end
         end
      end
   end

   assign bus.hreadyout = ready_out;
   assign bus.hresp     = resp_out;
   assign bus.hrdata    = rdata_out;

   // hburst is informational and the offset bits outside the storage window are not needed.
   logic unused_ok;
   assign unused_ok = ^{bus.hburst, bus.htrans[0], offset_ext[ADDR_WIDTH-1:MEM_ADDR_BITS],
                        offset_ext[NB_LOG2-1:0]};

endmodule

// File: doc/ahb_subordinate_mem_responder.md
Name: ahb_subordinate_mem_responder

Overview:
RTL AHB subordinate memory model that sits directly downstream of the master agent's driven bus and consumes its transfers. It answers each address/data-phase pair with hreadyout/hresp/hrdata, including programmable wait states and the two-cycle ERROR response. It stores write data per byte strobe, and gives the slave-side BFM and scoreboard a cycle-accurate DUT-like target.

Parameters:
ADDR_WIDTH, 32, haddr width
DATA_WIDTH, 32, hwdata/hrdata width (32 or 64)
MEM_ADDR_BITS, 12, byte-addressed storage depth = 2**MEM_ADDR_BITS bytes
MIN_ADDR, 32'h0000_0000, lowest mapped byte address
MAX_ADDR, 32'h0000_0FFF, highest mapped byte address; MAX_ADDR-MIN_ADDR+1 <= 2**MEM_ADDR_BITS
WAIT_WIDTH, 5, width of wait-state config (max 16)

Ports:
hclk  in  1  bus clock
hresetn  in  1  synchronous active-low reset
hselx  in  1  subordinate select
haddr  in  ADDR_WIDTH  transfer address
htrans  in  2  IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
hwrite  in  1  1=write 0=read
hsize  in  3  transfer size (BYTE=000 … LINE32=111)
hburst  in  3  burst type (informational; addresses taken from haddr)
hwdata  in  DATA_WIDTH  write data (data phase)
hwstrb  in  DATA_WIDTH/8  write strobes (data phase)
hready  in  1  combined bus ready
cfg_wait_states  in  WAIT_WIDTH  wait cycles inserted per accepted transfer
hreadyout  out  1  subordinate ready
hresp  out  1  0=OKAY 1=ERROR
hrdata  out  DATA_WIDTH  read data

Behaviour:
- Clock hclk. Reset: synchronous, active-low hresetn, sampled on rising edge. During and after reset: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, wait counter=0, latched phase cleared. Memory contents are not reset.
- Address-phase accept: rising edge with hready=1 and hselx=1. Captures haddr, hwrite, hsize, htrans, cfg_wait_states.
- Active transfer = htrans NONSEQ or SEQ.
- IDLE/BUSY, or hselx=0: next data phase is zero-wait OKAY with no memory access.
- Error check at accept, active transfers only. Flag ERROR if any of:
  - hsize > log2(DATA_WIDTH/8)
  - haddr not aligned to 2**hsize
  - haddr < MIN_ADDR
  - haddr+2**hsize-1 > MAX_ADDR
- FSM states: IDLE, WAIT, ERR1, ERR2, OKAY.
  - IDLE/OKAY: hreadyout=1, hresp=0. On active accept:
    - error -> ERR1
    - else cfg_wait_states>0 -> WAIT, counter=cfg_wait_states-1
    - else -> OKAY (zero-wait data phase next cycle)
  - WAIT: hreadyout=0, hresp=0, counter decrements each cycle. At 0 -> OKAY. Exactly N low cycles for cfg_wait_states=N.
  - ERR1: hreadyout=0, hresp=1, one cycle -> ERR2. No wait states precede an error.
  - ERR2: hreadyout=1, hresp=1. Also an address-phase accept point, with the same transitions as IDLE/OKAY.
  - Data phase with no new active accept -> IDLE.
- Pipelining: the final cycle of any data phase (hreadyout=1) accepts the next address phase, so back-to-back transfers run with no bubble.
- Write commit:
  - Happens on the completing edge of an OKAY write data phase (hreadyout=1, hready=1).
  - Byte lane i is written with hwdata[8i+7:8i] iff hwstrb[i]=1 and lane i lies inside the size/address lane mask.
  - Memory index = haddr - MIN_ADDR, truncated to MEM_ADDR_BITS. Lanes outside the mask are ignored.
  - ERROR writes never modify memory.
- Read data: in the completing cycle of an OKAY read data phase, hrdata = memory bytes at the aligned word containing the latched address; unaddressed lanes = 0. At all other times hrdata=0.
  - A read data phase immediately after a write data phase to the same address returns the new data (write commits before the read data phase).
- hburst is not checked. Wrap/incr address sequencing is the master's responsibility; each beat is error-checked independently.
- hreadyout does not affect local accept; only the external hready does (multi-subordinate correctness).
- Reset asserted mid-WAIT or mid-ERR1: next cycle IDLE with hreadyout=1 and hresp=0. The pending write is discarded.
- cfg_wait_states changes mid-transfer do not affect the current transfer.

Test Plan:
- Reset then NONSEQ WRITE WORD 0x10 data 0xDEADBEEF hwstrb=4'hF, 0 waits; then NONSEQ READ 0x10 -> second data phase hreadyout=1, hresp=0, hrdata=0xDEADBEEF, no bubble between phases.
- cfg_wait_states=3, READ 0x10 -> exactly 3 cycles hreadyout=0 hresp=0, then hreadyout=1 with data. Also cfg_wait_states=16 -> 16 low cycles.
- WRITE BYTE 0x13 hwdata=0xAA000000 hwstrb=4'hF, then READ WORD 0x10 -> hrdata=0xAAADBEEF (only lane 3 written). Repeat with hwstrb=4'h0 -> unchanged.
- WRITE WORD 0x1000 (above MAX_ADDR), and separately READ HALFWORD 0x11 (misaligned):
  - each gives one cycle hreadyout=0 hresp=1, then hreadyout=1 hresp=1
  - memory unchanged
  - a NONSEQ accepted during ERR2 then completes OKAY.
- INCR4 writes 0x20..0x2C with htrans NONSEQ,BUSY,SEQ,SEQ,SEQ -> BUSY data phase is zero-wait OKAY with no write; all four beats stored; readback matches.
- cfg_wait_states=5, write 0x40, deassert hresetn during 3rd wait cycle -> next cycle hreadyout=1 hresp=0, FSM IDLE; read 0x40 returns prior contents.
